// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI channel-voice decoder with running status and channel filter
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

module midi_msg_parser #(
    parameter int STROBE_DELAY = 1,
    parameter bit OMNI_DEFAULT = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          nrst_i,
    input  logic                          byte_ready_i,
    input  logic [`MIDI_PAYLOAD_BITS-1:0] byte_i,
    input  logic [3:0]                    channel_i,
    input  logic                          omni_i,
    output logic                          note_on_o,
    output logic                          note_off_o,
    output logic [6:0]                    note_o,
    output logic [6:0]                    velocity_o,
    output logic                          cc_valid_o,
    output logic [6:0]                    cc_num_o,
    output logic [6:0]                    cc_val_o,
    output logic [3:0]                    chan_o
);

    // OMNI_DEFAULT only records how omni_i is expected to be tied off
    // at integration; it intentionally drives no logic.
    if (OMNI_DEFAULT != 1'b0) begin : g_omni_default_doc
    end

    localparam logic [1:0] DLY_LOAD = 2'(STROBE_DELAY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Byte capture: rising-edge detect on ready, then a delay window
    // before byte_i is trusted (the frontend latches its data late).
    // ------------------------------------------------------------------
    logic       ready_q;
    logic [1:0] dly_cnt;
    logic       rise;
    logic       sample_fire;
    logic [7:0] byte_q;
    logic       byte_vld;

    assign rise        = byte_ready_i & ~ready_q;
    assign sample_fire = (STROBE_DELAY == 0) ? rise : (dly_cnt == 2'd1);

    // Edge detector, delay counter and captured-byte register
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ready_q  <= 1'b0;
            dly_cnt  <= 2'd0;
            byte_q   <= 8'h00;
            byte_vld <= 1'b0;
        end else begin
            ready_q  <= byte_ready_i;
            byte_vld <= sample_fire;
            if (sample_fire) begin
                byte_q <= byte_i;
            end
            // A new rising edge while the window is open is ignored.
            if (dly_cnt != 2'd0) begin
                dly_cnt <= dly_cnt - 2'd1;
            end else if (rise && (STROBE_DELAY != 0)) begin
                dly_cnt <= DLY_LOAD;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte classification
    // ------------------------------------------------------------------
    logic is_data;
    logic is_chan_status;
    logic is_sys;
    logic [6:0] d2;

    assign is_data        = ~byte_q[7];
    assign is_chan_status = byte_q[7] & (byte_q[7:4] != 4'hF);
    assign is_sys         = (byte_q[7:3] == 5'b11110);
    assign d2             = byte_q[6:0];

    // ------------------------------------------------------------------
    // Message FSM
    // ------------------------------------------------------------------
    state_t     state, state_n;
    logic [7:0] run_status, run_status_n;
    logic [6:0] d1, d1_n;
    logic       two_byte;
    logic       chan_match;
    logic       emit_on, emit_off, emit_cc;
    logic [6:0] ev_vel;

    assign two_byte   = (run_status[7:4] == 4'h8) || (run_status[7:4] == 4'h9) ||
                        (run_status[7:4] == 4'hA) || (run_status[7:4] == 4'hB) ||
                        (run_status[7:4] == 4'hE);
    assign chan_match = omni_i || (run_status[3:0] == channel_i);

    // State, running status and first data byte
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state      <= IDLE;
            run_status <= 8'h00;
            d1         <= 7'd0;
        end else begin
            state      <= state_n;
            run_status <= run_status_n;
            d1         <= d1_n;
        end
    end

    // Next-state decode and event generation for the captured byte
    always_comb begin
        state_n      = state;
        run_status_n = run_status;
        d1_n         = d1;
        emit_on      = 1'b0;
        emit_off     = 1'b0;
        emit_cc      = 1'b0;
        ev_vel       = d2;
        if (byte_vld) begin
            if (is_chan_status) begin
                // Also aborts any message pending in WAIT_D2.
                run_status_n = byte_q;
                state_n      = WAIT_D1;
            end else if (is_sys) begin
                run_status_n = 8'h00;
                state_n      = IDLE;
            end else if (is_data) begin
                case (state)
                    IDLE: begin
                        state_n = IDLE;
                    end
                    WAIT_D1: begin
                        d1_n = byte_q[6:0];
                        // One-data-byte types complete here and stay put.
                        state_n = two_byte ? WAIT_D2 : WAIT_D1;
                    end
                    WAIT_D2: begin
                        state_n = WAIT_D1;
                        if (chan_match) begin
                            case (run_status[7:4])
                                4'h8: emit_off = 1'b1;
                                4'h9: begin
                                    if (d2 != 7'd0) begin
                                        emit_on = 1'b1;
                                    end else begin
                                        emit_off = 1'b1;
                                        ev_vel   = 7'd0;
                                    end
                                end
                                4'hB: emit_cc = 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    default: begin
                        state_n = IDLE;
                    end
                endcase
            end
            // Realtime bytes fall through: nothing changes.
        end
    end

    // Registered event pulses and held fields
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            note_on_o  <= 1'b0;
            note_off_o <= 1'b0;
            cc_valid_o <= 1'b0;
            note_o     <= 7'd0;
            velocity_o <= 7'd0;
            cc_num_o   <= 7'd0;
            cc_val_o   <= 7'd0;
            chan_o     <= 4'd0;
        end else begin
            note_on_o  <= emit_on;
            note_off_o <= emit_off;
            cc_valid_o <= emit_cc;
            if (emit_on || emit_off) begin
                note_o     <= d1;
                velocity_o <= ev_vel;
            end
            if (emit_cc) begin
                cc_num_o <= d1;
                cc_val_o <= d2;
            end
            if (emit_on || emit_off || emit_cc) begin
                chan_o <= run_status[3:0];
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - scoreboard bench for midi_msg_parser
module tb_midi_msg_parser;

    localparam int D = 1;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_v = 8'h00;
    logic [3:0] channel = 4'd0;
    logic       omni = 1'b0;
    logic       note_on, note_off, cc_valid;
    logic [6:0] note, velocity, cc_num, cc_val;
    logic [3:0] chan;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int kind;   // 1 = note on, 2 = note off, 3 = cc
        int a;
        int b;
        int ch;
        int at;
    } ev_t;

    ev_t exp_q[$];

    midi_msg_parser #(.STROBE_DELAY(D), .OMNI_DEFAULT(1'b0)) dut (
        .clk_i       (clk),
        .nrst_i      (nrst),
        .byte_ready_i(byte_ready),
        .byte_i      (byte_v),
        .channel_i   (channel),
        .omni_i      (omni),
        .note_on_o   (note_on),
        .note_off_o  (note_off),
        .note_o      (note),
        .velocity_o  (velocity),
        .cc_valid_o  (cc_valid),
        .cc_num_o    (cc_num),
        .cc_val_o    (cc_val),
        .chan_o      (chan)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per emitted pulse
    always @(negedge clk) begin
        if (note_on || note_off || cc_valid) begin
            int kind_act;
            int a_act;
            int b_act;
            ev_t e;
            kind_act = note_on ? 1 : (note_off ? 2 : 3);
            a_act = cc_valid ? int'(cc_num) : int'(note);
            b_act = cc_valid ? int'(cc_val) : int'(velocity);
            chk("one_pulse", int'(note_on) + int'(note_off) + int'(cc_valid), 1);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event kind=%0d a=%0h b=%0h ch=%0d cycle=%0d",
                         kind_act, a_act, b_act, chan, cyc);
            end else begin
                e = exp_q.pop_front();
                if (kind_act != e.kind || a_act != e.a || b_act != e.b ||
                    int'(chan) != e.ch || cyc != e.at) begin
                    n_fail++;
                    $display("FAIL event actual kind=%0d a=%0h b=%0h ch=%0d cyc=%0d expected kind=%0d a=%0h b=%0h ch=%0d cyc=%0d",
                             kind_act, a_act, b_act, chan, cyc, e.kind, e.a, e.b, e.ch, e.at);
                end
            end
        end
    end

    // Drive one byte; optionally register the event it completes
    task automatic send(input logic [7:0] b, input int kind = 0, input int a = 0,
                        input int bv = 0, input int ch = 0);
        ev_t e;
        @(posedge clk);
        #1;
        if (kind != 0) begin
            e.kind = kind; e.a = a; e.b = bv; e.ch = ch;
            e.at = cyc + 1 + D + 1;
            exp_q.push_back(e);
        end
        byte_v     = b;
        byte_ready = 1'b1;
        repeat (D + 2) @(posedge clk);
        #1;
        byte_ready = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_note_on"}, note_on, 0);
        chk({tag, "_note_off"}, note_off, 0);
        chk({tag, "_cc_valid"}, cc_valid, 0);
        chk({tag, "_note"}, note, 0);
        chk({tag, "_velocity"}, velocity, 0);
        chk({tag, "_cc_num"}, cc_num, 0);
        chk({tag, "_cc_val"}, cc_val, 0);
        chk({tag, "_chan"}, chan, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        chk_all_zero("reset");
        nrst = 1'b1;
        idle(2);

        // Basic note on
        send(8'h90); send(8'h3C); send(8'h64, 1, 'h3C, 'h64, 0);

        // Running status, velocity-0 note on becomes note off
        send(8'h90); send(8'h40); send(8'h7F, 1, 'h40, 'h7F, 0);
        send(8'h40); send(8'h00, 2, 'h40, 'h00, 0);

        // Realtime interleave, omni
        omni = 1'b1;
        send(8'hB3); send(8'hF8); send(8'h07); send(8'hFE);
        send(8'h55, 3, 'h07, 'h55, 3);

        // Channel filter
        omni = 1'b0;
        channel = 4'd2;
        send(8'h91); send(8'h30); send(8'h40);
        idle(4);
        chk("hold_note", note, 'h40);
        chk("hold_velocity", velocity, 'h00);
        chk("hold_cc_num", cc_num, 'h07);
        chk("hold_cc_val", cc_val, 'h55);
        chk("hold_chan", chan, 3);
        send(8'h92); send(8'h30); send(8'h40, 1, 'h30, 'h40, 2);

        // Framing: program change skipped, then note on
        channel = 4'd0;
        send(8'hC0); send(8'h05); send(8'h90); send(8'h3C);
        send(8'h10, 1, 'h3C, 'h10, 0);

        // Status byte in WAIT_D2 aborts the pending message
        send(8'h90); send(8'h3C); send(8'h80); send(8'h3C);
        send(8'h20, 2, 'h3C, 'h20, 0);

        // System exclusive kills running status
        send(8'hF0); send(8'h3C); send(8'h10);
        idle(4);
        chk("sysex_hold_note", note, 'h3C);
        chk("sysex_hold_velocity", velocity, 'h20);

        // Reset mid-message
        send(8'h90); send(8'h3C);
        @(posedge clk);
        #1 nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        nrst = 1'b1;
        send(8'h50);
        idle(4);
        chk_all_zero("after_reset");

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
Downstream consumer of the MIDI RX frontend. Takes the deserialized 8-bit byte stream plus its ready strobe and decodes MIDI channel-voice messages with running status. Emits registered single-cycle Note-On, Note-Off and Control-Change events for one selectable channel (or omni) to the synth/voice logic. All other message types are consumed and discarded so byte framing stays correct.

Parameters:
STROBE_DELAY, 1, clock cycles from the rising edge of byte_ready_i to the edge that samples byte_i (covers the frontend latching its output register after asserting ready); legal range 0..3
OMNI_DEFAULT, 0, value used when omni_i is tied off; documentation only, no logic effect

Ports:
clk_i  input  1  system clock
nrst_i  input  1  asynchronous active-low reset
byte_ready_i  input  1  byte-available flag from the RX frontend; level or pulse, only its rising edge is used
byte_i  input  `MIDI_PAYLOAD_BITS (8)  received MIDI byte
channel_i  input  4  MIDI channel to accept (0..15, 0 = MIDI ch 1)
omni_i  input  1  1 = accept all channels, channel_i is ignored
note_on_o  output  1  one-cycle pulse: Note-On decoded
note_off_o  output  1  one-cycle pulse: Note-Off decoded, including Note-On with velocity 0
note_o  output  7  note number of the last note event, held
velocity_o  output  7  velocity of the last note event, held; forced to 0 for Note-On with velocity 0
cc_valid_o  output  1  one-cycle pulse: Control-Change decoded
cc_num_o  output  7  controller number, held
cc_val_o  output  7  controller value, held
chan_o  output  4  channel of the last emitted event, held

Behaviour:
- Reset (async, nrst_i low): all outputs 0, running status cleared, FSM in IDLE, edge detector previous value 0, delay line cleared. Reset mid-message discards the partial message.
- Byte capture: a rising edge of byte_ready_i is detected on clock edge k. byte_i is sampled on edge k+STROBE_DELAY. With STROBE_DELAY=0 it is sampled on edge k. A second rising edge inside the delay window is ignored.
- Event latency: pulse outputs and held fields update on the edge after the sample edge. Pulses last exactly one cycle. Held fields change only together with their pulse.
- Byte classes:
  - status 0x80-0xEF: load running status, clear data count, go to WAIT_D1.
  - realtime 0xF8-0xFF: ignored entirely; state, running status and the stored first data byte are unchanged.
  - system common/exclusive 0xF0-0xF7: clear running status and go to IDLE. Data bytes are then discarded until the next channel status byte.
  - data 0x00-0x7F: handled per state.
- FSM states:
  - IDLE: data bytes are discarded.
  - WAIT_D1: store byte as d1. For 2-data-byte types (0x8n, 0x9n, 0xAn, 0xBn, 0xEn) go to WAIT_D2. For 1-data-byte types (0xCn, 0xDn) the message is complete, no output, stay in WAIT_D1 (running status).
  - WAIT_D2: the message is complete; go back to WAIT_D1 (running status). Emit per type if the channel matches, otherwise emit nothing:
    - 0x8n: note_off_o, note_o=d1, velocity_o=d2.
    - 0x9n with d2≠0: note_on_o, note_o=d1, velocity_o=d2.
    - 0x9n with d2=0: note_off_o, note_o=d1, velocity_o=0.
    - 0xBn: cc_valid_o, cc_num_o=d1, cc_val_o=d2.
    - 0xAn, 0xEn: consumed, no output.
- Channel match: omni_i=1 or status[3:0]==channel_i, evaluated at message completion. chan_o=status[3:0].
- A status byte arriving in WAIT_D2 aborts the pending message with no output and starts the new one.
- At most one pulse output is high in any cycle.

Test Plan:
- channel_i=0, bytes 0x90,0x3C,0x64 -> one note_on_o pulse, note_o=0x3C, velocity_o=0x64, chan_o=0; latency = STROBE_DELAY+1 cycles after the third ready edge.
- Running status: 0x90,0x40,0x7F,0x40,0x00 -> note_on_o (0x40,0x7F), then note_off_o with note_o=0x40, velocity_o=0.
- Realtime interleave: 0xB3,0xF8,0x07,0xFE,0x55 with omni_i=1 -> single cc_valid_o, cc_num_o=0x07, cc_val_o=0x55, chan_o=3.
- Channel filter: channel_i=2, omni_i=0, 0x91,0x30,0x40 -> no pulses, outputs unchanged; then 0x92,0x30,0x40 -> note_on_o.
- Framing: 0xC0,0x05,0x90,0x3C,0x10 -> program change ignored, then note_on_o (0x3C,0x10); also 0xF0,0x3C,0x10 -> no output.
- Reset mid-message: 0x90,0x3C, then nrst_i low 2 cycles, then 0x50 -> no output, all outputs 0.
